code_mem_loader: RTL and testbench

Parametrised successor to the harness's byte-programmed code ROM. It holds a DEPTH_BYTES instruction memory with the following capabilities:
- Self-clearing fill sweep after reset or on request.
- valid/ready byte-stream loader with auto-incrementing address from a programmable base.
- Sticky overflow error and load-complete status.
- Little-endian fetch port of FETCH_BYTES width for the CPU DUT.

It sits between the host/testbench programming interface and the DUT's IMEM bus.

---
 rtl/code_mem_loader.sv | 182 ++++++++++++++++++
 tb/tb_code_mem_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_mem_loader.sv
// code_mem_loader: byte-programmed instruction memory with a self-clearing fill
// sweep, a valid/ready byte-stream loader and a little-endian fetch port.
// Optional feature macro: CODE_MEM_CHECKSUM_EN enables the running load checksum;
// when it is undefined, checksum is tied to zero.
module code_mem_loader #(
    parameter int unsigned DEPTH_BYTES     = 512,
    parameter int unsigned ADDR_W          = 12,
    parameter int unsigned FETCH_BYTES     = 4,
    parameter int unsigned CLEAR_PER_CYCLE = 4,
    parameter logic [7:0]  FILL_BYTE       = 8'hFF
) (
    input  logic                     hclk,
    input  logic                     reset_code_rom_n,
    input  logic                     clear_req,
    input  logic                     load_start,
    input  logic [ADDR_W-1:0]        load_base,
    input  logic                     load_valid,
    input  logic [7:0]               load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_done,
    output logic                     error,
    output logic                     busy,
    output logic [ADDR_W:0]          byte_count,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic [8*FETCH_BYTES-1:0] fetch_data,
    output logic [15:0]              checksum
);

    localparam int unsigned IDX_W   = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH_BYTES);
    localparam logic [PTR_W-1:0] STEP_P  = PTR_W'(CLEAR_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] clear_ptr_q, clear_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             mem_we_c;

    logic [7:0] mem_q [DEPTH_BYTES];

    // Next-state and datapath control for the CLEAR / IDLE / LOAD sequencer.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        done_d      = done_q;
        err_d       = err_q;
        mem_we_c    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                clear_ptr_d = clear_ptr_q + STEP_P;
                if ((clear_ptr_q + STEP_P) >= DEPTH_P) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    clear_ptr_d = '0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                end else if (load_start) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = {1'b0, load_base};
                    count_d  = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + PTR_W'(1);
                    if (wr_ptr_q < DEPTH_P) begin
                        mem_we_c = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                clear_ptr_d = '0;
            end
        endcase
    end

    // Control and status registers; reset restarts the sweep from address 0.
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Memory array: block fill during the sweep, single-byte writes while loading.
    always_ff @(posedge hclk) begin
        if (state_q == ST_CLEAR) begin
            for (int unsigned i = 0; i < CLEAR_PER_CYCLE; i++) begin
                mem_q[IDX_W'(clear_ptr_q + PTR_W'(i))] <= FILL_BYTE;
            end
        end else if (mem_we_c) begin
            mem_q[IDX_W'(wr_ptr_q)] <= load_data;
        end
    end

    // Little-endian combinational fetch; out-of-range bytes and the sweep read as fill.
    always_comb begin
        logic [PTR_W-1:0] byte_addr;
        byte_addr  = '0;
        fetch_data = '0;
        for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
            byte_addr = {1'b0, fetch_addr} + PTR_W'(k);
            if ((state_q == ST_CLEAR) || (byte_addr >= DEPTH_P)) begin
                fetch_data[8*k +: 8] = FILL_BYTE;
            end else begin
                fetch_data[8*k +: 8] = mem_q[IDX_W'(byte_addr)];
            end
        end
    end

`ifdef CODE_MEM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Running mod-2^16 sum of in-range accepted bytes, cleared when a load starts.
    always_comb begin
        sum_d = sum_q;
        if ((state_q == ST_IDLE) && !clear_req && load_start) begin
            sum_d = '0;
        end else if (mem_we_c) begin
            sum_d = sum_q + 16'(load_data);
        end
    end

    // Checksum register.
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign load_ready = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_IDLE);
    assign load_done  = done_q;
    assign error      = err_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_code_mem_loader.sv
// Self-checking bench for code_mem_loader: directed scenarios plus randomized
// loads compared against a byte-array reference model of the memory.
module tb_code_mem_loader;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 12;
    localparam int unsigned FB    = 4;

    logic          hclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_req = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready, load_done, error, busy;
    logic [AW:0]   byte_count;
    logic [AW-1:0] fetch_addr = '0;
    logic [31:0]   fetch_data;
    logic [15:0]   checksum;

    code_mem_loader dut (
        .hclk(hclk), .reset_code_rom_n(rst_n), .clear_req(clear_req),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .load_done(load_done), .error(error), .busy(busy), .byte_count(byte_count),
        .fetch_addr(fetch_addr), .fetch_data(fetch_data), .checksum(checksum)
    );

    always #5 hclk = ~hclk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic        ref_done, ref_err;
    int          ref_count;
    logic [15:0] ref_sum;
    logic [7:0]  load_q [$];

    function automatic logic [31:0] ref_fetch(input int unsigned a);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < FB; k++) begin
            if (a + 32'(k) >= DEPTH) w[8*k +: 8] = 8'hFF;
            else                     w[8*k +: 8] = ref_mem[9'(a + 32'(k))];
        end
        return w;
    endfunction

    function automatic logic [15:0] exp_sum();
`ifdef CODE_MEM_CHECKSUM_EN
        return ref_sum;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic ref_wipe();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
        ref_done = 1'b0;
        ref_err  = 1'b0;
    endtask

    task automatic run_sweep(output int n);
        n = 0;
        while (n < 1000) begin
            tick();
            n++;
            if (!busy) break;
        end
    endtask

    // gap: 0 = back-to-back, 1 = idle cycle between bytes, 2 = random idles with noise
    task automatic do_load(input logic [AW-1:0] base, input int gap);
        int unsigned addr;
        load_start = 1'b1;
        load_base  = base;
        tick();
        load_start = 1'b0;
        ref_done = 1'b0; ref_err = 1'b0; ref_count = 0; ref_sum = '0;
        for (int i = 0; i < load_q.size(); i++) begin
            if (gap == 1 && i > 0) begin
                load_valid = 1'b0;
                tick();
            end else if (gap == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    load_valid = 1'b0;
                    load_last  = 1'($urandom_range(0, 1));
                    clear_req  = 1'($urandom_range(0, 1));
                    load_start = 1'($urandom_range(0, 1));
                    load_base  = AW'($urandom);
                    tick();
                end
                clear_req  = 1'b0;
                load_start = 1'b0;
            end
            load_valid = 1'b1;
            load_data  = load_q[i];
            load_last  = (i == load_q.size() - 1);
            tick();
            addr = 32'(base) + 32'(i);
            if (addr < DEPTH) begin
                ref_mem[9'(addr)] = load_q[i];
                ref_sum = ref_sum + 16'(load_q[i]);
            end else begin
                ref_err = 1'b1;
            end
            ref_count++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        ref_done   = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", load_ready); end
        checks++; if (load_done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_status got done=%0b err=%0b want 0 0", load_done, error); end
        checks++; if (byte_count !== '0 || checksum !== 16'h0) begin errors++; $display("FAIL reset_counts got cnt=%0d sum=%h want 0 0", byte_count, checksum); end
        rst_n = 1'b1;
        ref_wipe();
        run_sweep(n);
        checks++; if (n != 128) begin errors++; $display("FAIL reset_sweep_len got %0d want 128", n); end
        fetch_addr = '0; #1;
        checks++; if (fetch_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_fetch0 got %h want ffffffff", fetch_data); end
    endtask

    task automatic test_basic_load();
        load_q = '{8'h13, 8'h37, 8'hBE, 8'hEF};
        do_load(AW'(12'h010), 0);
        checks++; if (load_done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_status got done=%0b err=%0b busy=%0b want 1 0 0", load_done, error, busy); end
        checks++; if (byte_count !== 13'd4) begin errors++; $display("FAIL basic_count got %0d want 4", byte_count); end
        fetch_addr = AW'(12'h010); #1;
        checks++; if (fetch_data !== 32'hEFBE_3713) begin errors++; $display("FAIL basic_fetch got %h want efbe3713", fetch_data); end
        checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL basic_checksum got %h want %h", checksum, exp_sum()); end
    endtask

    task automatic test_overflow();
        load_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_load(AW'(12'h1FE), 1);
        checks++; if (byte_count !== 13'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", byte_count); end
        checks++; if (error !== 1'b1 || load_done !== 1'b1) begin errors++; $display("FAIL ovf_status got err=%0b done=%0b want 1 1", error, load_done); end
        fetch_addr = AW'(12'h1FE); #1;
        checks++; if (fetch_data !== 32'hFFFF_BBAA) begin errors++; $display("FAIL ovf_fetch1fe got %h want ffffbbaa", fetch_data); end
        fetch_addr = AW'(12'h1FF); #1;
        checks++; if (fetch_data !== ref_fetch(32'h1FF)) begin errors++; $display("FAIL ovf_fetch1ff got %h want %h", fetch_data, ref_fetch(32'h1FF)); end
        checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL ovf_checksum got %h want %h", checksum, exp_sum()); end
    endtask

    task automatic test_same_cycle();
        logic [7:0] old_b;
        old_b = ref_mem[9'h020];
        load_start = 1'b1; load_base = AW'(12'h020);
        tick();
        load_start = 1'b0;
        fetch_addr = AW'(12'h020);
        load_valid = 1'b1; load_data = 8'h55; load_last = 1'b1;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %0b want 1", load_ready); end
        checks++; if (fetch_data[7:0] !== old_b) begin errors++; $display("FAIL same_old got %h want %h", fetch_data[7:0], old_b); end
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        ref_mem[9'h020] = 8'h55;
        checks++; if (fetch_data[7:0] !== 8'h55) begin errors++; $display("FAIL same_new got %h want 55", fetch_data[7:0]); end
        checks++; if (load_ready !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL same_end got rdy=%0b done=%0b want 0 1", load_ready, load_done); end
    endtask

    task automatic test_random_loads();
        logic [AW-1:0] base;
        int unsigned   fa;
        for (int it = 0; it < 24; it++) begin
            int len;
            len = int'($urandom_range(1, 10));
            case ($urandom_range(0, 3))
                0:       base = AW'(DEPTH - $urandom_range(0, 6));
                1:       base = AW'($urandom);
                default: base = AW'($urandom_range(0, DEPTH - 1));
            endcase
            load_q.delete();
            for (int i = 0; i < len; i++) load_q.push_back(8'($urandom));
            do_load(base, 2);
            checks++; if (load_done !== ref_done || error !== ref_err) begin errors++; $display("FAIL rnd_status it=%0d got done=%0b err=%0b want %0b %0b", it, load_done, error, ref_done, ref_err); end
            checks++; if (byte_count !== 13'(ref_count)) begin errors++; $display("FAIL rnd_count it=%0d got %0d want %0d", it, byte_count, ref_count); end
            checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL rnd_checksum it=%0d got %h want %h", it, checksum, exp_sum()); end
            for (int j = 0; j < 6; j++) begin
                fa = (j == 0) ? 32'(base) : ((j == 5) ? $urandom_range(0, 4095) : $urandom_range(0, DEPTH + 3));
                fetch_addr = AW'(fa); #1;
                checks++; if (fetch_data !== ref_fetch(fa)) begin errors++; $display("FAIL rnd_fetch it=%0d addr=%h got %h want %h", it, fa, fetch_data, ref_fetch(fa)); end
            end
        end
    endtask

    task automatic test_clear_priority();
        int n;
        load_q = '{8'h12, 8'h34};
        do_load(AW'(12'h1FF), 0);
        clear_req = 1'b1; load_start = 1'b1; load_base = AW'(12'h000);
        tick();
        clear_req = 1'b0; load_start = 1'b0;
        checks++; if (busy !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL prio_state got busy=%0b rdy=%0b want 1 0", busy, load_ready); end
        checks++; if (load_done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL prio_status got done=%0b err=%0b want 0 0", load_done, error); end
        fetch_addr = AW'(12'h1FC); #1;
        checks++; if (fetch_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL prio_fetch_during got %h want ffffffff", fetch_data); end
        ref_wipe();
        run_sweep(n);
        checks++; if (n != 128) begin errors++; $display("FAIL prio_sweep_len got %0d want 128", n); end
        for (int a = 0; a < DEPTH; a += 4) begin
            fetch_addr = AW'(a); #1;
            checks++; if (fetch_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL prio_fill addr=%h got %h want ffffffff", a, fetch_data); end
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        load_start = 1'b1; load_base = AW'(12'h040);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 8'($urandom_range(0, 254)); load_last = 1'b0;
            tick();
        end
        load_data = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy=%0b rdy=%0b want 1 0", busy, load_ready); end
        checks++; if (byte_count !== '0 || load_done !== 1'b0 || error !== 1'b0 || checksum !== 16'h0) begin errors++; $display("FAIL rstmid_status got cnt=%0d done=%0b err=%0b sum=%h want 0", byte_count, load_done, error, checksum); end
        fetch_addr = AW'(12'h040); #1;
        checks++; if (fetch_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_fetch got %h want ffffffff", fetch_data); end
        load_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        ref_wipe();
        run_sweep(n);
        checks++; if (n != 128) begin errors++; $display("FAIL rstmid_sweep_len got %0d want 128", n); end
        for (int a = 0; a < DEPTH; a += 4) begin
            fetch_addr = AW'(a); #1;
            checks++; if (fetch_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_fill addr=%h got %h want ffffffff", a, fetch_data); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_overflow();
        test_same_cycle();
        test_random_loads();
        test_clear_priority();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
